// File: rtl/assoc_cache_ctrl_if.sv
// assoc_cache_ctrl_if: CPU load/store and memory burst-refill bus of assoc_cache_ctrl
interface assoc_cache_ctrl_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_in;
  logic        cpu_we;
  logic        cpu_re;
  logic [3:0]  cpu_wstb;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_data_out;
  logic        miss;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_last;
  logic        mem_err;
  modport master (
    output cpu_addr, cpu_data_in, cpu_we, cpu_re, cpu_wstb, mem_data_in, mem_data_valid, mem_last,
    input  cpu_ready, cpu_done, cpu_data_out, miss, mem_req, mem_addr, mem_err
  );
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_we, cpu_re, cpu_wstb, mem_data_in, mem_data_valid, mem_last,
    output cpu_ready, cpu_done, cpu_data_out, miss, mem_req, mem_addr, mem_err
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative write-allocate cache with burst refill; ASSOC_CACHE_PLRU_EN selects tree pseudo-LRU over round-robin
module assoc_cache_ctrl #(
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 128
) (
  input logic              clk,
  input logic              reset_n,
  assoc_cache_ctrl_if.slave io_bus
);
  localparam int BEATS  = LINE_BYTES / 4;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LV     = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LV : 1;
  localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;
  typedef enum logic {S_READY, S_REFILL} state_t;
  state_t r_state, w_state_nxt;
  logic [31:0]       r_data  [SETS][WAYS][BEATS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0]   r_valid [SETS];
`ifdef ASSOC_CACHE_PLRU_EN
  logic [PL_W-1:0]   r_plru  [SETS];
`else
  logic [WAY_W-1:0]  r_rr    [SETS];
`endif
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tagv;
  logic [BEAT_W-1:0] r_word;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstb;
  logic              r_we;
  logic [WAY_W-1:0]  r_way;
  logic [BEAT_W-1:0] r_beat;
  logic [31:0]       r_req_word;
  logic              r_done;
  logic              r_req;
  logic              r_err;
  logic [31:0]       r_dout;
  logic [31:0]       r_maddr;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [BEAT_W-1:0] w_word;
  logic              w_ready;
  logic              w_miss;
  logic              w_acc;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_inv;
  logic [WAY_W-1:0]  w_vic;
  logic [WAY_W-1:0]  w_pol;
  logic [31:0]       w_hit_old;
  logic [31:0]       w_hit_dout;
  logic [31:0]       w_fill;
  logic              w_last_beat;
  logic              w_beat;
  logic              w_fin;
  logic              w_err;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return m;
  endfunction
`ifdef ASSOC_CACHE_PLRU_EN
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t, input logic [WAY_W-1:0] w);
    logic [PL_W-1:0] r;
    logic d;
    int n;
    r = t;
    n = 1;
    for (int l = 0; l < LV; l++) begin
      d = w[LV-1-l];
      r[n-1] = !d;
      n = 2 * n + int'(d);
    end
    return r;
  endfunction
  function automatic logic [WAY_W-1:0] plru_vic(input logic [PL_W-1:0] t);
    int n;
    n = 1;
    for (int l = 0; l < LV; l++) n = 2 * n + int'(t[n-1]);
    return WAY_W'(n - WAYS);
  endfunction
  assign w_pol = plru_vic(r_plru[w_idx]);
`else
  assign w_pol = r_rr[w_idx];
`endif
  assign w_idx       = io_bus.cpu_addr[OFF_W +: IDX_W];
  assign w_tag       = io_bus.cpu_addr[31 -: TAG_W];
  assign w_word      = io_bus.cpu_addr[2 +: BEAT_W];
  assign w_acc       = w_ready && (io_bus.cpu_re || io_bus.cpu_we);
  assign w_hit_old   = r_data[w_idx][w_hit_way][w_word];
  assign w_hit_dout  = io_bus.cpu_we ? merge(w_hit_old, io_bus.cpu_data_in, io_bus.cpu_wstb) : w_hit_old;
  assign w_fill      = (r_we && r_beat == r_word) ? merge(io_bus.mem_data_in, r_wdata, r_wstb) : io_bus.mem_data_in;
  assign w_last_beat = r_beat == BEAT_W'(BEATS - 1);
  assign w_beat      = w_miss && io_bus.mem_data_valid;
  assign w_fin       = w_beat && io_bus.mem_last && w_last_beat;
  assign w_err       = w_beat && (io_bus.mem_last ^ w_last_beat);
  assign io_bus.cpu_ready    = w_ready;
  assign io_bus.miss         = w_miss;
  assign io_bus.cpu_done     = r_done;
  assign io_bus.cpu_data_out = r_dout;
  assign io_bus.mem_req      = r_req;
  assign io_bus.mem_addr     = r_maddr;
  assign io_bus.mem_err      = r_err;
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_vic     = w_pol;
    for (int i = 0; i < WAYS; i++)
      if (r_valid[w_idx][i] && r_tag[w_idx][i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    for (int i = WAYS - 1; i >= 0; i--)
      if (!r_valid[w_idx][i]) begin
        w_inv = 1'b1;
        w_vic = WAY_W'(i);
      end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = r_state == S_READY;
    w_miss      = r_state == S_REFILL;
    w_state_nxt = w_ready ? ((w_acc && !w_hit) ? S_REFILL : S_READY)
                          : ((w_fin || w_err) ? S_READY : S_REFILL);
  end
  always_ff @(posedge clk)
    r_state <= !reset_n ? S_READY : w_state_nxt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid    <= '{default: '0};
`ifdef ASSOC_CACHE_PLRU_EN
      r_plru     <= '{default: '0};
`else
      r_rr       <= '{default: '0};
`endif
      r_idx      <= '0;
      r_tagv     <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_wstb     <= '0;
      r_we       <= 1'b0;
      r_way      <= '0;
      r_beat     <= '0;
      r_req_word <= '0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
      r_maddr    <= '0;
    end else begin
      r_done <= 1'b0;
      r_req  <= 1'b0;
      if (w_acc) begin
        r_idx   <= w_idx;
        r_tagv  <= w_tag;
        r_word  <= w_word;
        r_wdata <= io_bus.cpu_data_in;
        r_wstb  <= io_bus.cpu_wstb;
        r_we    <= io_bus.cpu_we;
        if (w_hit) begin
          r_done <= 1'b1;
          r_dout <= w_hit_dout;
`ifdef ASSOC_CACHE_PLRU_EN
          r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
`endif
        end else begin
          r_req                 <= 1'b1;
          r_maddr               <= {io_bus.cpu_addr[31:OFF_W], {OFF_W{1'b0}}};
          r_way                 <= w_vic;
          r_valid[w_idx][w_vic] <= 1'b0;
`ifdef ASSOC_CACHE_PLRU_EN
          r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_vic);
`else
          if (!w_inv) r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
`endif
        end
      end
      if (w_beat) begin
        r_maddr <= r_maddr + 32'd4;
        r_beat  <= r_beat + 1'b1;
        if (r_beat == r_word) r_req_word <= w_fill;
        if (w_fin) begin
          r_valid[r_idx][r_way] <= 1'b1;
          r_done                <= 1'b1;
          r_dout                <= (r_beat == r_word) ? w_fill : r_req_word;
          r_beat                <= '0;
        end
        if (w_err) begin
          r_err  <= 1'b1;
          r_beat <= '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n && w_acc && w_hit && io_bus.cpu_we) r_data[w_idx][w_hit_way][w_word] <= w_hit_dout;
    if (reset_n && w_beat) r_data[r_idx][r_way][r_beat] <= w_fill;
    if (reset_n && w_fin) r_tag[r_idx][r_way] <= r_tagv;
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: directed scoreboard bench for assoc_cache_ctrl
module tb_assoc_cache_ctrl;
  localparam int BEATS = 32;
  logic clk;
  logic reset_n;
  int n_cmp;
  int n_err;
  logic [31:0] q[$];
  assoc_cache_ctrl_if bus();
  assoc_cache_ctrl #(.SETS(64), .WAYS(4), .LINE_BYTES(128)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io_bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input int op, input logic [31:0] d, input logic [3:0] s,
                       input logic push, input logic [31:0] exp);
    if (push) q.push_back(exp);
    bus.cpu_addr    = a;
    bus.cpu_we      = (op != 0);
    bus.cpu_re      = (op != 1);
    bus.cpu_data_in = d;
    bus.cpu_wstb    = s;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask
  task automatic check_done();
    cmp("cpu_done", 32'(bus.cpu_done), 32'd1);
    if (q.size() != 0) cmp("cpu_data_out", bus.cpu_data_out, q.pop_front());
    else cmp("scoreboard_underflow", 32'(q.size()), 32'd1);
  endtask
  task automatic miss_start(input logic [31:0] base);
    cmp("mem_req", 32'(bus.mem_req), 32'd1);
    cmp("mem_addr_start", bus.mem_addr, base);
    cmp("miss_high", 32'(bus.miss), 32'd1);
    cmp("ready_low", 32'(bus.cpu_ready), 32'd0);
    cmp("done_low_refill", 32'(bus.cpu_done), 32'd0);
  endtask
  task automatic feed(input logic [31:0] base, input logic [31:0] seed, input logic [31:0] step, input int last_at);
    for (int k = 0; k < BEATS; k++) begin
      cmp("mem_addr_beat", bus.mem_addr, base + 32'(k) * 32'd4);
      if (k == 1) cmp("mem_req_pulse", 32'(bus.mem_req), 32'd0);
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = seed + 32'(k) * step;
      bus.mem_last       = (k == last_at);
      @(negedge clk);
      if (k == last_at) break;
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_last       = 1'b0;
  endtask
  task automatic hit(input logic [31:0] a, input int op, input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    issue(a, op, d, s, 1'b1, exp);
    cmp("mem_req_on_hit", 32'(bus.mem_req), 32'd0);
    cmp("miss_on_hit", 32'(bus.miss), 32'd0);
    check_done();
  endtask
  task automatic miss_fill(input logic [31:0] a, input int op, input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp, input logic [31:0] seed, input logic [31:0] step);
    logic [31:0] base;
    base = {a[31:7], 7'd0};
    issue(a, op, d, s, 1'b1, exp);
    miss_start(base);
    feed(base, seed, step, BEATS - 1);
    check_done();
    cmp("miss_cleared", 32'(bus.miss), 32'd0);
    cmp("ready_back", 32'(bus.cpu_ready), 32'd1);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n            = 1'b0;
    bus.cpu_addr       = '0;
    bus.cpu_data_in    = '0;
    bus.cpu_we         = 1'b0;
    bus.cpu_re         = 1'b0;
    bus.cpu_wstb       = '0;
    bus.mem_data_in    = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_last       = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_ready", 32'(bus.cpu_ready), 32'd1);
    cmp("rst_done", 32'(bus.cpu_done), 32'd0);
    cmp("rst_miss", 32'(bus.miss), 32'd0);
    cmp("rst_mem_req", 32'(bus.mem_req), 32'd0);
    cmp("rst_mem_err", 32'(bus.mem_err), 32'd0);
    cmp("rst_data_out", bus.cpu_data_out, 32'd0);
    cmp("rst_mem_addr", bus.mem_addr, 32'd0);
    reset_n = 1'b1;
    miss_fill(32'h1000, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h55555555);
    hit(32'h1000, 0, 32'h0, 4'h0, 32'h0);
    hit(32'h1008, 0, 32'h0, 4'h0, 32'hAAAAAAAA);
    hit(32'h1008, 1, 32'h12345678, 4'b1100, 32'h1234AAAA);
    hit(32'h1008, 0, 32'h0, 4'h0, 32'h1234AAAA);
    miss_fill(32'h7004, 1, 32'hAAAAAAAA, 4'b0011, 32'hFFFFAAAA, 32'hFFFFFFFF, 32'h0);
    hit(32'h7004, 0, 32'h0, 4'h0, 32'hFFFFAAAA);
    hit(32'h7000, 0, 32'h0, 4'h0, 32'hFFFFFFFF);
    hit(32'h100C, 2, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    hit(32'h100C, 0, 32'h0, 4'h0, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++)
      miss_fill(32'(i) * 32'h2000, 0, 32'h0, 4'h0, 32'(i) * 32'h2000, 32'(i) * 32'h2000, 32'h1);
    hit(32'h2004, 0, 32'h0, 4'h0, 32'h2001);
    miss_fill(32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h1);
    issue(32'h10000, 0, 32'h0, 4'h0, 1'b0, 32'h0);
    miss_start(32'h10000);
    feed(32'h10000, 32'h0, 32'h1, 5);
    cmp("err_early_last", 32'(bus.mem_err), 32'd1);
    cmp("err_ready", 32'(bus.cpu_ready), 32'd1);
    cmp("err_no_done", 32'(bus.cpu_done), 32'd0);
    cmp("err_miss_low", 32'(bus.miss), 32'd0);
    issue(32'h10000, 0, 32'h0, 4'h0, 1'b0, 32'h0);
    miss_start(32'h10000);
    feed(32'h10000, 32'h0, 32'h1, -1);
    cmp("err_missing_last", 32'(bus.mem_err), 32'd1);
    cmp("err2_ready", 32'(bus.cpu_ready), 32'd1);
    cmp("err2_no_done", 32'(bus.cpu_done), 32'd0);
    miss_fill(32'h10000, 0, 32'h0, 4'h0, 32'h10000, 32'h10000, 32'h1);
    cmp("err_sticky", 32'(bus.mem_err), 32'd1);
    hit(32'h1000, 0, 32'h0, 4'h0, 32'h0);
    issue(32'h9000, 0, 32'h0, 4'h0, 1'b0, 32'h0);
    miss_start(32'h9000);
    for (int k = 0; k < 10; k++) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = 32'(k);
      @(negedge clk);
    end
    bus.mem_data_in = 32'd10;
    reset_n         = 1'b0;
    @(negedge clk);
    bus.mem_data_valid = 1'b0;
    cmp("rr_miss_low", 32'(bus.miss), 32'd0);
    cmp("rr_ready", 32'(bus.cpu_ready), 32'd1);
    cmp("rr_no_done", 32'(bus.cpu_done), 32'd0);
    cmp("rr_err_cleared", 32'(bus.mem_err), 32'd0);
    reset_n = 1'b1;
    miss_fill(32'h1000, 0, 32'h0, 4'h0, 32'h11110000, 32'h11110000, 32'h1);
    for (int i = 0; i < 4; i++)
      miss_fill(32'h80 + 32'(i) * 32'h2000, 0, 32'h0, 4'h0, 32'h80 + 32'(i) * 32'h2000, 32'h80 + 32'(i) * 32'h2000, 32'h1);
    hit(32'h80, 0, 32'h0, 4'h0, 32'h80);
    miss_fill(32'h8080, 0, 32'h0, 4'h0, 32'h8080, 32'h8080, 32'h1);
`ifdef ASSOC_CACHE_PLRU_EN
    hit(32'h80, 0, 32'h0, 4'h0, 32'h80);
    miss_fill(32'h4080, 0, 32'h0, 4'h0, 32'h4080, 32'h4080, 32'h1);
`else
    hit(32'h4080, 0, 32'h0, 4'h0, 32'h4080);
    miss_fill(32'h80, 0, 32'h0, 4'h0, 32'h80, 32'h80, 32'h1);
`endif
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised N-way set-associative, write-allocate CPU-side cache with burst line refill from memory.
- Successor to the fixed 64-set / 4-way / 128-byte controller: parallel tag compare across all ways replaces address-selected ways, with victim selection, request handshake and protocol-error detection.
- Sits between the CPU load/store port and the AXI burst read master.

Parameters:
- SETS, 64, number of sets; power of 2, at least 2.
- WAYS, 4, associativity; power of 2, 1 to 8.
- LINE_BYTES, 128, line size; power of 2, 8 to 256.
- Derived: BEATS=LINE_BYTES/4; OFF_W=log2(LINE_BYTES); IDX_W=log2(SETS); TAG_W=32-IDX_W-OFF_W.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_addr  in  32  byte address, word aligned.
- cpu_data_in  in  32  write data.
- cpu_we  in  1  write request, 1-cycle pulse.
- cpu_re  in  1  read request, 1-cycle pulse.
- cpu_wstb  in  4  byte enables for writes.
- cpu_ready  out  1  high while a request can be accepted.
- cpu_done  out  1  1-cycle completion pulse.
- cpu_data_out  out  32  requested word after the merged write; valid while cpu_done=1.
- miss  out  1  high while a refill is in progress.
- mem_req  out  1  1-cycle pulse that starts a refill.
- mem_addr  out  32  address of the current beat.
- mem_data_in  in  32  refill beat data.
- mem_data_valid  in  1  beat strobe.
- mem_last  in  1  final-beat marker, qualified by mem_data_valid.
- mem_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - All valid bits and replacement state cleared; state=READY.
  - cpu_ready=1; cpu_done=0; miss=0; mem_req=0; mem_err=0; cpu_data_out=0; mem_addr=0.
  - Reset during REFILL abandons the refill; no cpu_done is issued.
- Request acceptance:
  - A request is accepted on an edge where (cpu_re|cpu_we) and cpu_ready=1.
  - Requests while cpu_ready=0 are ignored.
  - If cpu_re and cpu_we are both high, the request is treated as a write.
  - The accept edge latches addr, data, wstb and op.
- Lookup: combinational at accept. Hit = any way in set addr[OFF_W+IDX_W-1:OFF_W] with valid=1 and tag==addr[31:32-TAG_W].
- Hit:
  - Writes update the addressed bytes per wstb at the accept edge.
  - Next cycle: cpu_done=1 and cpu_data_out=line word; state stays READY.
  - Hit latency is 1 cycle.
  - The replacement state is updated to mark the hit way most recently used.
- Miss:
  - Next cycle: state=REFILL, miss=1, cpu_ready=0, mem_req=1 for 1 cycle.
  - mem_addr = addr with offset bits zeroed.
  - Victim is the lowest-index invalid way; otherwise it comes from the replacement policy.
  - The victim's valid bit is cleared on entry to REFILL.
- REFILL:
  - Each mem_data_valid writes mem_data_in to victim word beat_cnt, then increments beat_cnt and advances mem_addr by 4.
  - Final beat = mem_data_valid with mem_last and beat_cnt==BEATS-1. On that edge: tag written, valid=1, pending write merged per wstb.
  - Next cycle: state=READY, miss=0, cpu_ready=1, cpu_done=1, cpu_data_out = requested word, post-merge.
- Protocol errors:
  - Error cases: mem_last with beat_cnt!=BEATS-1, or beat_cnt==BEATS-1 with mem_data_valid and no mem_last.
  - Response: mem_err=1 (sticky until reset), victim left invalid, state returns to READY next cycle, no cpu_done.
- Counters: beat_cnt is log2(BEATS) bits and wraps to 0 on leaving REFILL. The round-robin pointer wraps from WAYS-1 to 0.

Optional Feature:
- Macro: ASSOC_CACHE_PLRU_EN.
- Defined: tree pseudo-LRU, WAYS-1 bits per set.
  - An access flips the tree bits along its path away from the accessed way.
  - The victim is found by following the bits.
  - WAYS=1 degenerates to way 0.
- Undefined: one round-robin pointer per set, advanced only when a victim is consumed on a miss; hits leave it unchanged.

Test Plan:
- Reset, then read 0x0000_1000 with beats 0x0,0x55555555,... -> mem_req plus mem_addr=0x1000; after 32 beats, cpu_done with cpu_data_out=beat0; re-read 0x1000 hits with done 1 cycle later and no mem_req.
- Write 0xAAAAAAAA, wstb=4'b0011, to 0x1004 after line filled with 0xFFFFFFFF -> read 0x1004 returns 0xFFFFAAAA.
- Five lines mapping to set 0 (stride SETS*LINE_BYTES=0x2000), no PLRU -> fifth miss evicts way 0; re-read of first line misses.
- mem_last on beat 5 -> mem_err=1, cpu_ready=1 next cycle, no cpu_done; next read of same address misses again.
- reset_n=0 on beat 10 of refill -> next cycle miss=0, cpu_ready=1, cpu_done=0; all prior hits now miss.
- With ASSOC_CACHE_PLRU_EN: fill ways 0-3, touch way 0, then miss -> way 2 evicted.
